// File: rtl/uart_transmitter.sv
`timescale 1ns/1ps
// UART transmitter: byte in over valid/ready, frame out LSB-first as
// start, 8 data, optional parity, 1 stop. Bit period selected by BC.
module uart_transmitter #(
    parameter bit          ODD_PARITY  = 1'b0,
    parameter int unsigned DIV_DEFAULT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] BC,
    input  logic       PbitEna,
    input  logic [7:0] DataIn,
    input  logic       TxStart,
    output logic       Ready,
    output logic       Tx_out,
    output logic       TxDone,
    output logic       ena
);

    localparam int unsigned CNT_W  = 9;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    last_q, last_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                pbit_q, pbit_d;
    logic                ready_d, tx_d, done_d, ena_d;
    logic [CNT_W-1:0]    last_sel_c;
    logic                bit_end_c;
    logic                parity_c;

    // Divisor table stores DIV-1 so the bit counter wraps on a plain compare
    always_comb begin
        case (BC)
            3'b001:  last_sel_c = CNT_W'(216);
            3'b010:  last_sel_c = CNT_W'(108);
            3'b011:  last_sel_c = CNT_W'(71);
            3'b100:  last_sel_c = CNT_W'(35);
            default: last_sel_c = CNT_W'(DIV_DEFAULT - 1);
        endcase
    end

    assign bit_end_c = (cnt_q == last_q);
    assign parity_c  = (^data_q) ^ ODD_PARITY;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, datapath updates and registered-output next values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        idx_d   = idx_q;
        data_d  = data_q;
        pbit_d  = pbit_q;
        ready_d = Ready;
        tx_d    = 1'b1;
        done_d  = 1'b0;
        ena_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (TxStart && Ready) begin
                    state_d = S_START;
                    data_d  = DataIn;
                    last_d  = last_sel_c;
                    pbit_d  = PbitEna;
                    cnt_d   = '0;
                    idx_d   = '0;
                    ready_d = 1'b0;
                end
            end
            S_START, S_DATA, S_PARITY, S_STOP: begin
                ready_d = 1'b0;
                cnt_d   = bit_end_c ? '0 : cnt_q + CNT_W'(1);
                if (bit_end_c) begin
                    ena_d = 1'b1;
                end
                // Line level reflects the bit currently being timed
                case (state_q)
                    S_START:  tx_d = 1'b0;
                    S_DATA:   tx_d = data_q[idx_q[2:0]];
                    S_PARITY: tx_d = parity_c;
                    default:  tx_d = 1'b1;
                endcase
                if (bit_end_c) begin
                    case (state_q)
                        S_START: begin
                            state_d = S_DATA;
                            idx_d   = '0;
                        end
                        S_DATA: begin
                            if (idx_q == IDX_W'(7)) begin
                                state_d = pbit_q ? S_PARITY : S_STOP;
                                idx_d   = '0;
                            end else begin
                                idx_d = idx_q + IDX_W'(1);
                            end
                        end
                        S_PARITY: begin
                            state_d = S_STOP;
                        end
                        default: begin
                            state_d = S_IDLE;
                            ready_d = 1'b1;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            last_q <= '0;
            idx_q  <= '0;
            data_q <= '0;
            pbit_q <= 1'b0;
            Ready  <= 1'b1;
            Tx_out <= 1'b1;
            TxDone <= 1'b0;
            ena    <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
            idx_q  <= idx_d;
            data_q <= data_d;
            pbit_q <= pbit_d;
            Ready  <= ready_d;
            Tx_out <= tx_d;
            TxDone <= done_d;
            ena    <= ena_d;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
`timescale 1ns/1ps
// Self-checking bench for uart_transmitter: directed frame table, reset
// abort sequence, and randomized frames against a frame-level model.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] BC;
    logic       PbitEna;
    logic [7:0] DataIn;
    logic       TxStart;
    logic       Ready;
    logic       Tx_out;
    logic       TxDone;
    logic       ena;

    int compared = 0;
    int mismatched = 0;

    uart_transmitter dut (
        .clk     (clk),
        .reset   (reset),
        .BC      (BC),
        .PbitEna (PbitEna),
        .DataIn  (DataIn),
        .TxStart (TxStart),
        .Ready   (Ready),
        .Tx_out  (Tx_out),
        .TxDone  (TxDone),
        .ena     (ena)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [2:0] bc;
        logic       pbit;
        bit         hold;
        int         perturb_k;
        int         exp_div;
        logic       exp_par;
        int         exp_len;
    } vec_t;

    task automatic check(input string name, input int got, input int exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int div_of(input logic [2:0] bc);
        int t [8] = '{434, 217, 109, 72, 36, 434, 434, 434};
        return t[bc];
    endfunction

    // Entered at a negedge where the DUT is idle; returns at the negedge
    // following the final stop-bit edge (Ready high again).
    task automatic run_frame(input string name, input logic [7:0] d,
                             input logic [2:0] bc, input logic pb,
                             input bit hold, input bit scramble,
                             input int perturb_k, input int div,
                             input logic par, input int n);
        logic [10:0] frame;
        int nb;
        int tx_bad, rdy_bad, done_bad, ena_bad, low_len, first_bad;
        logic exp_tx;
        nb = pb ? 11 : 10;
        frame = '1;
        frame[0] = 1'b0;
        for (int i = 0; i < 8; i++) frame[1+i] = d[i];
        if (pb) frame[9] = par;
        tx_bad = 0; rdy_bad = 0; done_bad = 0; ena_bad = 0; low_len = 0;
        first_bad = -1;
        DataIn = d; BC = bc; PbitEna = pb; TxStart = 1'b1;
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            exp_tx = (k == 0) ? 1'b1 : frame[(k-1)/div];
            if (Tx_out !== exp_tx) begin
                tx_bad++;
                if (first_bad < 0) first_bad = k;
            end
            if (Ready !== (k == n)) rdy_bad++;
            if (TxDone !== (k == n)) done_bad++;
            if (ena !== (k > 0 && (k % div) == 0)) ena_bad++;
            if (Ready === 1'b0) low_len++;
            if (!hold) TxStart = 1'b0;
            if (scramble && k > 0 && k < n) begin
                TxStart = 1'($urandom);
                DataIn  = 8'($urandom);
                BC      = 3'($urandom);
                PbitEna = 1'($urandom);
            end
            if (k == perturb_k) begin
                BC = 3'b100; DataIn = 8'hFF; TxStart = 1'b1;
            end
            if (k == n && !hold) TxStart = 1'b0;
        end
        check({name, " tx bad cycles (first at ", $sformatf("%0d", first_bad), ")"}, tx_bad, 0);
        check({name, " ready bad cycles"}, rdy_bad, 0);
        check({name, " txdone bad cycles"}, done_bad, 0);
        check({name, " ena bad cycles"}, ena_bad, 0);
        check({name, " ready low length"}, low_len, n);
    endtask

    task automatic idle_cycles(input int g);
        int bad;
        bad = 0;
        TxStart = 1'b0;
        for (int i = 0; i < g; i++) begin
            @(negedge clk);
            if (Ready !== 1'b1 || Tx_out !== 1'b1 || TxDone !== 1'b0 || ena !== 1'b0) bad++;
        end
        check("idle gap outputs", bad, 0);
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{8'hA5, 3'b000, 1'b1, 1'b0, -1, 434, 1'b0, 4774};
        vecs[1] = '{8'h4F, 3'b100, 1'b1, 1'b0, -1, 36,  1'b1, 396};
        vecs[2] = '{8'h00, 3'b011, 1'b0, 1'b0, -1, 72,  1'b0, 720};
        vecs[3] = '{8'h3C, 3'b001, 1'b0, 1'b0, 1000, 217, 1'b0, 2170};
        vecs[4] = '{8'h81, 3'b100, 1'b1, 1'b1, -1, 36,  1'b0, 396};
        vecs[5] = '{8'h7E, 3'b100, 1'b1, 1'b0, -1, 36,  1'b0, 396};

        reset = 1'b0; BC = '0; PbitEna = 1'b0; DataIn = '0; TxStart = 1'b0;
        repeat (3) @(negedge clk);
        check("reset Tx_out", 32'(Tx_out), 1);
        check("reset Ready", 32'(Ready), 1);
        check("reset TxDone", 32'(TxDone), 0);
        check("reset ena", 32'(ena), 0);
        reset = 1'b1;
        idle_cycles(3);

        for (int v = 0; v < 6; v++) begin
            run_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].bc, vecs[v].pbit,
                      vecs[v].hold, 1'b0, vecs[v].perturb_k, vecs[v].exp_div,
                      vecs[v].exp_par, vecs[v].exp_len);
            if (v == 4) continue;
            idle_cycles(2);
        end

        // Reset asserted during D3 of 8'hA5 aborts the frame immediately
        DataIn = 8'hA5; BC = 3'b000; PbitEna = 1'b1; TxStart = 1'b1;
        @(negedge clk);
        TxStart = 1'b0;
        repeat (4*434 + 100) @(negedge clk);
        check("pre-reset Tx_out in D3", 32'(Tx_out), 0);
        check("pre-reset Ready", 32'(Ready), 0);
        #3 reset = 1'b0;
        #1;
        check("async reset Tx_out", 32'(Tx_out), 1);
        check("async reset Ready", 32'(Ready), 1);
        check("async reset TxDone", 32'(TxDone), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle_cycles(500);
        run_frame("after reset 5A", 8'h5A, 3'b000, 1'b0, 1'b0, 1'b0, -1,
                  434, 1'b0, 4340);

        // Randomized frames with scrambled inputs while busy
        for (int r = 0; r < 16; r++) begin
            logic [7:0] d;
            logic [2:0] bc;
            logic pb;
            int div;
            d  = 8'($urandom);
            bc = (r < 14) ? 3'($urandom_range(1, 4)) : 3'($urandom_range(5, 7));
            pb = 1'($urandom);
            div = div_of(bc);
            run_frame($sformatf("rand%0d d=%02h bc=%0d p=%0d", r, d, bc, pb),
                      d, bc, pb, 1'b0, 1'b1, -1, div,
                      1'(($countones(d) % 2) != 0), div * (pb ? 11 : 10));
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
